// File: rtl/pipe_stage_reg.sv
// Pipeline register chain for the MIPS core. Moves a data/control bundle with a
// per-stage valid bit, and supports stall, flush, kill-all and a bubble counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DEPTH  = 1,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              kill_all_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [2:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned     OCC_W   = 3;
  localparam logic [CNT_W-1:0] BUB_MAX = '1;

  logic [DEPTH-1:0]  stg_valid;
  logic [DATA_W-1:0] stg_data [DEPTH];
  logic [CTRL_W-1:0] stg_ctrl [DEPTH];
  logic [OCC_W-1:0]  occ_q;
  logic [CNT_W-1:0]  bub_q;

  logic [DEPTH-1:0]  nxt_valid;
  logic [DATA_W-1:0] nxt_data [DEPTH];
  logic [CTRL_W-1:0] nxt_ctrl [DEPTH];
  logic [OCC_W-1:0]  nxt_occ;
  logic [CNT_W-1:0]  nxt_bub;
  logic              cap_valid;

  // Next-state of every stage: kill beats stall beats flush beats advance.
  always_comb begin
    nxt_valid = stg_valid;
    nxt_data  = stg_data;
    nxt_ctrl  = stg_ctrl;
    nxt_bub   = bub_q;
    cap_valid = valid_in & ~flush_in;

    if (kill_all_in) begin
      for (int k = 0; k < DEPTH; k++) begin
        nxt_valid[k] = 1'b0;
        nxt_ctrl[k]  = stg_ctrl[k] & ~KILL_MASK;
      end
    end else if (!stall_in) begin
      for (int k = 1; k < DEPTH; k++) begin
        nxt_valid[k] = stg_valid[k-1];
        nxt_data[k]  = stg_data[k-1];
        nxt_ctrl[k]  = stg_ctrl[k-1];
      end
      // Any non-valid capture (bubble or idle slot) carries masked controls.
      nxt_valid[0] = cap_valid;
      nxt_data[0]  = data_in;
      nxt_ctrl[0]  = cap_valid ? ctrl_in : (ctrl_in & ~KILL_MASK);
      if (flush_in && (bub_q != BUB_MAX)) begin
        nxt_bub = bub_q + CNT_W'(1);
      end
    end
  end

  // Occupancy is registered alongside the stages, so count the next valid bits.
  always_comb begin
    nxt_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      nxt_occ = nxt_occ + OCC_W'(nxt_valid[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stg_data[k] <= '0;
        stg_ctrl[k] <= '0;
      end
      occ_q <= '0;
      bub_q <= '0;
    end else begin
      stg_valid <= nxt_valid;
      stg_data  <= nxt_data;
      stg_ctrl  <= nxt_ctrl;
      occ_q     <= nxt_occ;
      bub_q     <= nxt_bub;
    end
  end

  assign valid_out  = stg_valid[DEPTH-1];
  assign data_out   = stg_data[DEPTH-1];
  assign ctrl_out   = stg_ctrl[DEPTH-1];
  assign occupancy  = occ_q;
  assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three depths driven by shared stimulus, compared
// each cycle against a queue-based reference of the pipeline contents.
module tb_pipe_stage_reg;

  localparam int unsigned NI = 3;
  localparam logic [15:0] MASK1 = 16'h0007;
  localparam logic [15:0] MASK2 = 16'hFFFF;
  localparam logic [15:0] MASK3 = 16'h00E0;

  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, kill_all_in, valid_in;
  logic [31:0] data_in;
  logic [15:0] ctrl_in;

  logic        vo   [NI];
  logic [31:0] dout [NI];
  logic [15:0] cout [NI];
  logic [2:0]  occ  [NI];
  logic [3:0]  bub  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: queue front = newest capture, back = the stage seen at the output.
  bit          mv [NI][$];
  logic [31:0] md [NI][$];
  logic [15:0] mc [NI][$];
  logic [15:0] kmask [NI];
  int          mbub;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(1), .KILL_MASK(MASK1), .CNT_W(4)) u_d1 (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .kill_all_in(kill_all_in), .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in),
    .valid_out(vo[0]), .data_out(dout[0]), .ctrl_out(cout[0]), .occupancy(occ[0]),
    .bubble_cnt(bub[0]));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(2), .KILL_MASK(MASK2), .CNT_W(4)) u_d2 (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .kill_all_in(kill_all_in), .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in),
    .valid_out(vo[1]), .data_out(dout[1]), .ctrl_out(cout[1]), .occupancy(occ[1]),
    .bubble_cnt(bub[1]));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(3), .KILL_MASK(MASK3), .CNT_W(4)) u_d3 (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .kill_all_in(kill_all_in), .valid_in(valid_in), .data_in(data_in), .ctrl_in(ctrl_in),
    .valid_out(vo[2]), .data_out(dout[2]), .ctrl_out(cout[2]), .occupancy(occ[2]),
    .bubble_cnt(bub[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_valid(input int i);
    int n = 0;
    for (int j = 0; j < mv[i].size(); j++) n += int'(mv[i][j]);
    return n;
  endfunction

  task automatic model_step(input bit r, input bit st, input bit fl, input bit k,
                            input bit v, input logic [31:0] d, input logic [15:0] c);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        mv[i].delete(); md[i].delete(); mc[i].delete();
        for (int j = 0; j <= i; j++) begin
          mv[i].push_back(1'b0); md[i].push_back('0); mc[i].push_back('0);
        end
      end else if (k) begin
        for (int j = 0; j < mv[i].size(); j++) begin
          mv[i][j] = 1'b0;
          mc[i][j] = mc[i][j] & ~kmask[i];
        end
      end else if (!st) begin
        mv[i].push_front(v && !fl);
        md[i].push_front(d);
        mc[i].push_front((v && !fl) ? c : (c & ~kmask[i]));
        void'(mv[i].pop_back()); void'(md[i].pop_back()); void'(mc[i].pop_back());
      end
    end
    if (r) mbub = 0;
    else if (!k && !st && fl && mbub < 15) mbub++;
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int last = mv[i].size() - 1;
      chk($sformatf("d%0d.valid_out", i + 1), 32'(vo[i]),   32'(mv[i][last]));
      chk($sformatf("d%0d.data_out", i + 1),  dout[i],      md[i][last]);
      chk($sformatf("d%0d.ctrl_out", i + 1),  32'(cout[i]), 32'(mc[i][last]));
      chk($sformatf("d%0d.occupancy", i + 1), 32'(occ[i]),  32'(count_valid(i)));
      chk($sformatf("d%0d.bubble_cnt", i + 1), 32'(bub[i]), 32'(mbub));
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input bit r, input bit st, input bit fl, input bit k,
                       input bit v, input logic [31:0] d, input logic [15:0] c);
    reset = r; stall_in = st; flush_in = fl; kill_all_in = k;
    valid_in = v; data_in = d; ctrl_in = c;
    @(posedge clk);
    model_step(r, st, fl, k, v, d, c);
    #1;
    check_all();
  endtask

  initial begin
    kmask[0] = MASK1; kmask[1] = MASK2; kmask[2] = MASK3;
    mbub = 0;

    // Reset, then a steady stream of one value.
    cycle(1, 0, 0, 0, 1, 32'h1234_5678, 16'h00FF);
    cycle(1, 0, 0, 0, 1, 32'h1234_5678, 16'h00FF);
    chk("rst.d2.occ", 32'(occ[1]), 32'd0);
    cycle(0, 0, 0, 0, 1, 32'h1234_5678, 16'h00FF);
    chk("first.d2.valid", 32'(vo[1]), 32'd0);
    chk("first.d2.occ", 32'(occ[1]), 32'd1);
    cycle(0, 0, 0, 0, 1, 32'h1234_5678, 16'h00FF);
    chk("lat2.d2.valid", 32'(vo[1]), 32'd1);
    chk("lat2.d2.data", dout[1], 32'h1234_5678);
    chk("lat2.d2.occ", 32'(occ[1]), 32'd2);

    // One-cycle flush pulse.
    cycle(0, 0, 1, 0, 1, 32'hAAAA_0001, 16'h00FF);
    chk("flush.d1.valid", 32'(vo[0]), 32'd0);
    chk("flush.d1.ctrl", 32'(cout[0]), 32'h00F8);
    chk("flush.d1.bub", 32'(bub[0]), 32'd1);
    cycle(0, 0, 0, 0, 1, 32'hAAAA_0002, 16'h00FF);
    chk("post_flush.d1.ctrl", 32'(cout[0]), 32'h00FF);
    chk("post_flush.d1.valid", 32'(vo[0]), 32'd1);

    // Stream A,B,C, then a 4-cycle stall with a flush inside it.
    cycle(0, 0, 0, 0, 1, 32'h0000_000A, 16'h0A0A);
    cycle(0, 0, 0, 0, 1, 32'h0000_000B, 16'h0B0B);
    cycle(0, 0, 0, 0, 1, 32'h0000_000C, 16'h0C0C);
    chk("abc.d3.data", dout[2], 32'h0000_000A);
    for (int s = 0; s < 4; s++)
      cycle(0, 1, (s == 2), 0, 1, 32'hDEAD_0000 + 32'(s), 16'(16'h1111 * (s + 1)));
    chk("stall.d3.data", dout[2], 32'h0000_000A);
    chk("stall.bub", 32'(bub[2]), 32'd1);
    cycle(0, 0, 0, 0, 1, 32'h0000_000D, 16'h0D0D);
    chk("resume.d3.data", dout[2], 32'h0000_000B);
    cycle(0, 0, 0, 0, 1, 32'h0000_000E, 16'h0E0E);
    chk("resume2.d3.data", dout[2], 32'h0000_000C);

    // Full pipe killed while stalled.
    cycle(0, 0, 0, 0, 1, 32'h0000_00F1, 16'hFFFF);
    cycle(0, 0, 0, 0, 1, 32'h0000_00F2, 16'hFFFF);
    cycle(0, 0, 0, 0, 1, 32'h0000_00F3, 16'hFFFF);
    chk("full.d3.occ", 32'(occ[2]), 32'd3);
    cycle(0, 1, 1, 1, 1, 32'h0000_00F4, 16'hFFFF);
    chk("kill.d3.occ", 32'(occ[2]), 32'd0);
    chk("kill.d3.ctrl", 32'(cout[2]), 32'hFF1F);
    chk("kill.d3.data", dout[2], 32'h0000_00F1);

    // Hold flush for 20 advancing cycles: counter saturates, reset clears.
    for (int s = 0; s < 20; s++) cycle(0, 0, 1, 0, 1, 32'(s), 16'h00FF);
    chk("sat.bub", 32'(bub[0]), 32'd15);
    cycle(1, 0, 0, 0, 0, '0, '0);
    chk("sat_rst.bub", 32'(bub[0]), 32'd0);

    // Reset with two valid entries in flight.
    cycle(0, 0, 0, 0, 1, 32'h5555_0001, 16'h0101);
    cycle(0, 0, 0, 0, 1, 32'h5555_0002, 16'h0202);
    cycle(1, 0, 0, 0, 0, '0, '0);
    chk("midrst.d2.valid", 32'(vo[1]), 32'd0);
    chk("midrst.d2.data", dout[1], 32'd0);
    cycle(0, 0, 0, 0, 0, 32'h7777_7777, 16'h0000);
    cycle(0, 0, 0, 0, 0, 32'h7777_7777, 16'h0000);
    chk("midrst.d2.gone", 32'(vo[1]), 32'd0);

    // Random traffic.
    for (int s = 0; s < 400; s++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 4),
            ($urandom_range(0, 99) < 80), $urandom(), 16'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register for the pipelined MIPS core. Generalises the fixed per-stage registers (ID/EX and similar) into one block.
- Carries a data bundle and a control bundle through DEPTH back-to-back stages, with a per-stage valid bit.
- Supports a global stall, bubble insertion (flush), whole-pipe kill, and a saturating bubble counter for performance monitoring.
- Instantiated between decode and execute, and reused for the multi-cycle EX/MEM paths.

Parameters:
- DATA_W, 32: width of the data bundle (operands, immediates, PC).
- CTRL_W, 16: width of the control bundle (ALU, memory and writeback controls).
- DEPTH, 1: number of chained register stages; legal range 1..4.
- KILL_MASK, {CTRL_W{1'b1}}: control bits forced to 0 when a stage holds a bubble. Side-effecting controls (MemRead, MemWrite, RegWrite) must be set.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_in  input  1  hold every stage unchanged this cycle.
- flush_in  input  1  capture a bubble into stage 0 instead of the input bundle.
- kill_all_in  input  1  invalidate every stage (exception/redirect).
- valid_in  input  1  the input bundle is a real instruction.
- data_in  input  DATA_W  data bundle from the upstream stage.
- ctrl_in  input  CTRL_W  control bundle from the upstream stage.
- valid_out  output  1  valid bit of the last stage.
- data_out  output  DATA_W  data bundle of the last stage.
- ctrl_out  output  CTRL_W  control bundle of the last stage.
- occupancy  output  3  count of valid stages, 0..DEPTH.
- bubble_cnt  output  CNT_W  saturating count of bubbles inserted by flush_in.

Behaviour:
- Reset (synchronous, active-high, highest priority): all stage valid=0, data=0, ctrl=0, bubble_cnt=0. Consequently valid_out=0, data_out=0, ctrl_out=0, occupancy=0 on the cycle after reset is sampled high. Reset mid-stream discards all in-flight entries; nothing is drained.
- Priority when reset=0: kill_all_in > stall_in > flush_in > normal advance.
- kill_all_in=1:
  - every stage gets valid=0 and ctrl &= ~KILL_MASK; data is held.
  - stall_in and flush_in are ignored; bubble_cnt is not incremented.
- stall_in=1 (kill_all_in=0): every stage holds valid, data and ctrl. flush_in is ignored and bubble_cnt is unchanged. Stall has no length limit.
- Normal advance (no stall, no kill), each rising edge:
  - stage k receives stage k-1 for k=1..DEPTH-1.
  - stage 0 receives {valid_in, data_in, ctrl_in}.
  - latency from input to output is exactly DEPTH cycles.
- flush_in=1 with advance:
  - stage 0 captures valid=0, data=data_in, ctrl=ctrl_in & ~KILL_MASK.
  - the other stages advance normally.
  - bubble_cnt increments by 1, saturating at 2^CNT_W-1 (no wrap).
- valid_in=0 with advance, no flush: stage 0 captures ctrl_in & ~KILL_MASK. This guarantees that every invalid stage has its masked controls at 0.
- Outputs are driven combinationally from the last stage's registers; there is no combinational path from any input to any output.
- occupancy is the registered popcount of the stage valid bits and is updated on the same edge as the stages.
- DEPTH=1 degenerates to a single register with flush semantics that match the existing per-stage registers.
- No handshake back-pressure: the upstream stage is responsible for honouring stall_in (hazard unit drives it).

Test Plan:
- DEPTH=2, reset=1 for 2 cycles, then release with valid_in=1, data_in=0x12345678, ctrl_in=0x00FF each cycle -> valid_out=0 and ctrl_out=0 during reset and on the first post-reset cycle; data_out=0x12345678 and valid_out=1 exactly 2 cycles after the first capture; occupancy steps 0,1,2.
- DEPTH=1, KILL_MASK=0x0007, ctrl_in=0x00FF, flush_in pulsed 1 cycle -> that cycle's output has valid_out=0 and ctrl_out=0x00F8; bubble_cnt=1; the next cycle passes 0x00FF with valid_out=1.
- DEPTH=3, stream A,B,C, stall_in high for 4 cycles while ctrl_in changes -> outputs frozen on the same entry for 4 cycles; a flush during the stall leaves bubble_cnt unchanged; the stream resumes in order with no loss or duplication.
- DEPTH=3 full pipe (occupancy=3), kill_all_in=1 together with stall_in=1 -> next cycle occupancy=0, valid_out=0, masked ctrl bits 0, data_out unchanged.
- CNT_W=4, flush_in held for 20 advancing cycles -> bubble_cnt saturates at 15 and stays there; reset returns it to 0.
- DEPTH=2, reset asserted while 2 valid entries are in flight -> the next cycle valid_out=0, occupancy=0, data_out=0; the entries never appear at the output.
